// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, synchronous flush and a saturating stall counter.
// Define PIPE_STAGE_SKID_EN to add a skid entry and a registered in_ready; the default build holds one beat.
module pipe_stage_reg #(
  parameter int                    DATA_WIDTH      = 96,
  parameter logic [DATA_WIDTH-1:0] NOP_DATA        = {DATA_WIDTH{1'b0}},
  parameter int                    STALL_CNT_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_WIDTH-1:0]      in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_WIDTH-1:0]      out_data,
  output logic [STALL_CNT_WIDTH-1:0] stall_count
);

  function automatic logic [STALL_CNT_WIDTH-1:0] sat_inc(input logic [STALL_CNT_WIDTH-1:0] v);
    if (&v) return v;
    return v + {{(STALL_CNT_WIDTH-1){1'b0}}, 1'b1};
  endfunction

  logic                       r_valid_p1;
  logic [DATA_WIDTH-1:0]      r_data_p1;
  logic [STALL_CNT_WIDTH-1:0] r_stall_cnt;
  logic                       w_in_fire;
  logic                       w_out_fire;

  assign w_in_fire   = in_valid && in_ready;
  assign w_out_fire  = r_valid_p1 && out_ready;
  assign out_valid   = r_valid_p1;
  assign out_data    = r_data_p1;
  assign stall_count = r_stall_cnt;

`ifdef PIPE_STAGE_SKID_EN
  logic                  r_skid_valid_p1;
  logic [DATA_WIDTH-1:0] r_skid_data_p1;

  // in_ready comes straight from a flop, so out_ready never reaches it combinationally.
  assign in_ready = !r_skid_valid_p1;

  // ---- stage p1: main + skid entries ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid_p1      <= 1'b0;
      r_data_p1       <= NOP_DATA;
      r_skid_valid_p1 <= 1'b0;
    end else if (flush) begin
      r_valid_p1      <= 1'b0;
      r_data_p1       <= NOP_DATA;
      r_skid_valid_p1 <= 1'b0;
    end else if (r_skid_valid_p1) begin
      // Skid only fills behind a valid main entry, so main stays valid while it drains.
      if (out_ready) begin
        r_data_p1       <= r_skid_data_p1;
        r_skid_valid_p1 <= 1'b0;
      end
    end else if (w_in_fire && r_valid_p1 && !out_ready) begin
      r_skid_valid_p1 <= 1'b1;
    end else if (w_in_fire) begin
      r_data_p1  <= in_data;
      r_valid_p1 <= 1'b1;
    end else if (w_out_fire) begin
      r_valid_p1 <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!r_skid_valid_p1 && w_in_fire && r_valid_p1 && !out_ready)
      r_skid_data_p1 <= in_data;
  end
`else
  assign in_ready = !r_valid_p1 || out_ready;

  // ---- stage p1: single main entry ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid_p1 <= 1'b0;
      r_data_p1  <= NOP_DATA;
    end else if (flush) begin
      r_valid_p1 <= 1'b0;
      r_data_p1  <= NOP_DATA;
    end else if (w_in_fire) begin
      r_data_p1  <= in_data;
      r_valid_p1 <= 1'b1;
    end else if (w_out_fire) begin
      r_valid_p1 <= 1'b0;
    end
  end
`endif

  // ---- stall counter: survives flush, cleared only by reset ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_stall_cnt <= '0;
    else if (r_valid_p1 && !out_ready)
      r_stall_cnt <= sat_inc(r_stall_cnt);
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register with valid/ready handshake, synchronous flush and saturating stall counter. It generalises the fixed-width enable-only inter-stage registers (fetch→decode and later stages) into one width-configurable block. It sits between any two pipeline stages: upstream drives `in_*`, downstream consumes `out_*`. Flush inserts a bubble, and stall back-pressure propagates through `in_ready`.

## Interface
- `DATA_WIDTH`, 96: payload width; 96 carries PC, PC+4 and instruction.
- `NOP_DATA`, `{DATA_WIDTH{1'b0}}`: payload value driven after reset and flush; decode's NOP encoding goes in the low bits.
- `STALL_CNT_WIDTH`, 16: width of the stall counter.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `flush`  in  1  synchronous bubble insert; highest priority.
- `in_valid`  in  1  upstream beat valid.
- `in_ready`  out  1  stage can accept a beat.
- `in_data`  in  DATA_WIDTH  upstream payload.
- `out_valid`  out  1  registered beat valid.
- `out_ready`  in  1  downstream accepts the beat.
- `out_data`  out  DATA_WIDTH  registered payload.
- `stall_count`  out  STALL_CNT_WIDTH  cycles with `out_valid && !out_ready`.

## Operation
- Storage:
  - main register `valid_q`/`data_q` drives `out_valid`/`out_data`.
  - optional skid entry `skid_valid`/`skid_data` (see Configuration).
- Input fire: `in_valid && in_ready`. Output fire: `out_valid && out_ready`.
- Non-skid mode:
  - `in_ready = !valid_q || out_ready`, combinational.
  - On input fire, `data_q <= in_data` and `valid_q <= 1`.
  - Otherwise, on output fire, `valid_q <= 0`.
  - Simultaneous in/out fire replaces the entry; there is no bubble.
- Skid mode:
  - `in_ready = !skid_valid`, registered.
  - Input fire while `valid_q && !out_ready` → beat goes to skid.
  - Input fire otherwise → beat goes to main.
  - On output fire with `skid_valid`: main ← skid and `skid_valid <= 0`.
  - Order is always preserved.
- `data_q` holds its last value while `valid_q = 0`, except after reset or flush, when it equals `NOP_DATA`.
- Flush, when `flush = 1` at the edge:
  - `valid_q <= 0`, `skid_valid <= 0`, `data_q <= NOP_DATA`.
  - Any beat presented that cycle is discarded, even if `in_ready = 1`.
  - Flush overrides fire and stall.
- Stall counter:
  - Increments when `out_valid && !out_ready`.
  - Saturates at all-ones.
  - Cleared only by reset, not by flush.
- Reset values: `out_valid = 0`, `out_data = NOP_DATA`, `in_ready = 1`, skid empty, `stall_count = 0`.

## Timing
- Latency: a beat accepted at edge N is visible on `out_*` after edge N.
- Throughput: 1 beat/cycle in steady state, in both modes.
- Non-skid mode: `in_ready` falls in the same cycle as `out_ready` (combinational path `out_ready` → `in_ready`).
- Skid mode:
  - `in_ready` falls one cycle after the first stalled input is captured into skid.
  - `in_ready` rises the cycle after skid drains.
  - There is no combinational path from `out_ready` to `in_ready`.
- Flush takes effect at the edge: `out_valid = 0` the cycle after flush is sampled. In skid mode, `in_ready = 1` that same cycle.
- Async reset asserted mid-transfer: all state clears immediately, and no beat is produced after release until a new input fire.
- Capacity:
  - One entry full: non-skid accepts only if draining the same cycle.
  - Two entries full (skid): `in_ready = 0`.

## Configuration
- `PIPE_STAGE_SKID_EN` defined:
  - skid entry is instantiated.
  - `in_ready` is registered, breaking the ready timing path.
  - Capacity is 2 beats.
- Not defined:
  - no skid storage.
  - `in_ready` is combinational as described.
  - Capacity is 1 beat.
- Ports and parameters are identical in both builds.

## Test plan
- Reset mid-stream with `DATA_WIDTH = 96`, `NOP_DATA = 96'h13` → `out_valid = 0`, `out_data = 96'h13`, `in_ready = 1`, `stall_count = 0`.
- Stream beats A, B, C with `out_ready = 1` → outputs A, B, C on consecutive cycles, 1-cycle latency.
- Hold `out_ready = 0` for 3 cycles with A valid:
  - non-skid: `in_ready = 0`, A held.
  - skid: B accepted, then `in_ready = 0`.
  - Both modes: release gives A then B in order, and `stall_count = 3`.
- Assert `flush` with a valid beat pending and `in_valid = 1` → next cycle `out_valid = 0`, `out_data = NOP_DATA`, skid empty, flushed-cycle input never appears.
- Force 70 000 stall cycles with `STALL_CNT_WIDTH = 16` → `stall_count` saturates at `16'hFFFF`.
- Present simultaneous input and output fire every cycle for 100 beats → no beat lost or duplicated, and scoreboard matches.
